zoom_pixel_engine: RTL and testbench

ZOOM_PIXEL_ENGINE -- requirements
Module: zoom_pixel_engine

---
 rtl/zoom_pkg.sv | 48 ++++
 rtl/zoom_coord_counter.sv | 63 ++++++
 rtl/zoom_pixel_engine.sv | 135 +++++++++++++
 tb/tb_zoom_pixel_engine.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/zoom_pkg.sv
// rtl/zoom_pkg.sv - shared encodings, mode and state enums for the zoom pixel engine
// Optional feature macro used by the bundle: ZOOM_BA_ROUND_EN
package zoom_pkg;

  localparam logic [1:0] ALG_NN = 2'd0;
  localparam logic [1:0] ALG_PR = 2'd1;
  localparam logic [1:0] ALG_DC = 2'd2;
  localparam logic [1:0] ALG_BA = 2'd3;

  localparam logic [1:0] IMG_DEFAULT  = 2'd0;
  localparam logic [1:0] IMG_ENLARGED = 2'd1;
  localparam logic [1:0] IMG_REDUCED  = 2'd2;

  typedef enum logic [1:0] {
    MODE_COPY = 2'd0,
    MODE_ENL  = 2'd1,
    MODE_DEC  = 2'd2,
    MODE_AVG  = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WT   = 3'd2,
    ST_OUT  = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  // Reserved image state falls back to a straight copy.
  function automatic mode_t select_mode(input logic [1:0] img, input logic [1:0] alg);
    mode_t m;
    m = MODE_COPY;
    case (img)
      IMG_DEFAULT:  m = MODE_COPY;
      IMG_ENLARGED: m = MODE_ENL;
      IMG_REDUCED: begin
        case (alg)
          ALG_NN, ALG_PR, ALG_DC: m = MODE_DEC;
          ALG_BA:                 m = MODE_AVG;
          default:                m = MODE_DEC;
        endcase
      end
      default:      m = MODE_COPY;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/zoom_coord_counter.sv
// rtl/zoom_coord_counter.sv - raster x/y output counters with per-mode wrap limits
// Also flags the bottom-right pixel of the current output frame.
module zoom_coord_counter
  import zoom_pkg::*;
#(
  parameter int W_SRC = 160,
  parameter int H_SRC = 120,
  parameter int X_W   = 9,
  parameter int Y_W   = 8
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           clear,
  input  logic           step,
  input  logic [1:0]     mode,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic [X_W-1:0] x_lim;
  logic [Y_W-1:0] y_lim;

  always_comb begin
    x_lim = X_W'(W_SRC - 1);
    y_lim = Y_W'(H_SRC - 1);
    case (mode_t'(mode))
      MODE_COPY: begin
        x_lim = X_W'(W_SRC - 1);
        y_lim = Y_W'(H_SRC - 1);
      end
      MODE_ENL: begin
        x_lim = X_W'(2 * W_SRC - 1);
        y_lim = Y_W'(2 * H_SRC - 1);
      end
      MODE_DEC, MODE_AVG: begin
        x_lim = X_W'(W_SRC / 2 - 1);
        y_lim = Y_W'(H_SRC / 2 - 1);
      end
      default: begin
        x_lim = X_W'(W_SRC - 1);
        y_lim = Y_W'(H_SRC - 1);
      end
    endcase
  end

  assign last = (x == x_lim) && (y == y_lim);

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (x == x_lim) begin
        x <= '0;
        y <= (y == y_lim) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/zoom_pixel_engine.sv
// rtl/zoom_pixel_engine.sv - frame zoom engine: copy, 2x enlarge, 2x decimate or 2x2 average
// ZOOM_BA_ROUND_EN defined rounds the 2x2 average; undefined truncates it.
module zoom_pixel_engine
  import zoom_pkg::*;
#(
  parameter int W_SRC  = 160,
  parameter int H_SRC  = 120,
  parameter int ADDR_W = 15
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [1:0]        ALGORITHM,
  input  logic [1:0]        IMAGE_STATE,
  output logic              SRC_RD,
  output logic [ADDR_W-1:0] SRC_ADDR,
  input  logic [7:0]        SRC_DATA,
  output logic [7:0]        DST_DATA,
  output logic              DST_VALID,
  input  logic              DST_READY,
  output logic              DST_LAST,
  output logic              BUSY,
  output logic              DONE
);

  localparam int X_W = $clog2(2 * W_SRC);
  localparam int Y_W = $clog2(2 * H_SRC);

  state_t         state, state_nxt;
  mode_t          mode;
  logic [1:0]     rd_idx;
  logic [9:0]     acc;
  logic [9:0]     sum;
  logic [9:0]     sum_adj;
  logic [7:0]     pix;
  logic [X_W-1:0] x, sx;
  logic [Y_W-1:0] y, sy;
  logic           last;
  logic           start_ok;
  logic           xfer;

  assign start_ok = (state == ST_IDLE) && START;
  assign xfer     = (state == ST_OUT) && DST_READY;

  zoom_coord_counter #(
    .W_SRC(W_SRC),
    .H_SRC(H_SRC),
    .X_W  (X_W),
    .Y_W  (Y_W)
  ) u_coord (
    .clk   (CLK),
    .resetn(RESET_N),
    .clear (start_ok),
    .step  (xfer),
    .mode  (mode),
    .x     (x),
    .y     (y),
    .last  (last)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (START) state_nxt = ST_RD;
      ST_RD:   state_nxt = ST_WT;
      ST_WT:   state_nxt = (mode == MODE_AVG && rd_idx != 2'd3) ? ST_RD : ST_OUT;
      ST_OUT:  if (DST_READY) state_nxt = last ? ST_FIN : ST_RD;
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // AVG walks the 2x2 block as (0,0),(1,0),(0,1),(1,1) using rd_idx bits.
  always_comb begin
    sx = x;
    sy = y;
    case (mode)
      MODE_COPY: begin sx = x;                            sy = y;                            end
      MODE_ENL:  begin sx = x >> 1;                       sy = y >> 1;                       end
      MODE_DEC:  begin sx = {x[X_W-2:0], 1'b0};           sy = {y[Y_W-2:0], 1'b0};           end
      MODE_AVG:  begin sx = {x[X_W-2:0], rd_idx[0]};      sy = {y[Y_W-2:0], rd_idx[1]};      end
      default:   begin sx = x;                            sy = y;                            end
    endcase
  end

  assign sum = acc + {2'b00, SRC_DATA};
`ifdef ZOOM_BA_ROUND_EN
  assign sum_adj = sum + 10'd2;
`else
  assign sum_adj = sum;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      mode   <= MODE_COPY;
      rd_idx <= '0;
      acc    <= '0;
      pix    <= '0;
    end else begin
      if (start_ok) begin
        mode   <= select_mode(IMAGE_STATE, ALGORITHM);
        rd_idx <= '0;
        acc    <= '0;
      end
      if (state == ST_WT) begin
        if (mode == MODE_AVG) begin
          if (rd_idx == 2'd3) begin
            pix    <= 8'(sum_adj >> 2);
            acc    <= '0;
            rd_idx <= '0;
          end else begin
            acc    <= sum;
            rd_idx <= rd_idx + 2'd1;
          end
        end else begin
          pix <= SRC_DATA;
        end
      end
    end
  end

  assign SRC_RD    = (state == ST_RD);
  assign SRC_ADDR  = SRC_RD ? (ADDR_W'(sy) * ADDR_W'(W_SRC) + ADDR_W'(sx)) : '0;
  assign DST_VALID = (state == ST_OUT);
  assign DST_LAST  = DST_VALID && last;
  assign DST_DATA  = pix;
  assign BUSY      = (state != ST_IDLE) && (state != ST_FIN);
  assign DONE      = (state == ST_FIN);

endmodule

// File: tb/tb_zoom_pixel_engine.sv
// tb/tb_zoom_pixel_engine.sv - directed frame bench for zoom_pixel_engine on a small 8x6 image
// Expected AVG values follow ZOOM_BA_ROUND_EN.
module tb_zoom_pixel_engine;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int AW = 8;
`ifdef ZOOM_BA_ROUND_EN
  localparam int AVG_BLK   = 2;  // (7+2)>>2
  localparam int AVG_RAMP0 = 5;  // (18+2)>>2
`else
  localparam int AVG_BLK   = 1;  // 7>>2
  localparam int AVG_RAMP0 = 4;  // 18>>2
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [1:0]    algorithm;
  logic [1:0]    image_state;
  logic          src_rd;
  logic [AW-1:0] src_addr;
  logic [7:0]    src_data = 8'd0;
  logic [7:0]    dst_data;
  logic          dst_valid;
  logic          dst_ready;
  logic          dst_last;
  logic          busy;
  logic          done;

  logic [7:0] ram [0:255];
  int         out_buf [0:255];
  int         n_vec = 0;
  int         n_err = 0;
  int         got_count;

  always #5 clk = ~clk;

  always @(posedge clk) if (src_rd) src_data <= ram[src_addr];

  zoom_pixel_engine #(.W_SRC(W), .H_SRC(H), .ADDR_W(AW)) dut (
    .CLK        (clk),
    .RESET_N    (resetn),
    .START      (start),
    .ALGORITHM  (algorithm),
    .IMAGE_STATE(image_state),
    .SRC_RD     (src_rd),
    .SRC_ADDR   (src_addr),
    .SRC_DATA   (src_data),
    .DST_DATA   (dst_data),
    .DST_VALID  (dst_valid),
    .DST_READY  (dst_ready),
    .DST_LAST   (dst_last),
    .BUSY       (busy),
    .DONE       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_ramp();
    for (int a = 0; a < 256; a++) ram[a] = 8'(a);
  endtask

  // Top-left of every 2x2 block is 1, the other three are 2.
  task automatic fill_blocks();
    for (int a = 0; a < 256; a++)
      ram[a] = ((a % W) % 2 == 0 && ((a / W) % 2) == 0) ? 8'd1 : 8'd2;
  endtask

  function automatic int mode_of(input int img, input int alg);
    if (img == 1) return 1;
    if (img == 2) return (alg == 3) ? 3 : 2;
    return 0;
  endfunction

  function automatic int out_w(input int m);
    return (m == 0) ? W : (m == 1) ? 2 * W : W / 2;
  endfunction

  function automatic int out_h(input int m);
    return (m == 0) ? H : (m == 1) ? 2 * H : H / 2;
  endfunction

  function automatic int exp_val(input int m, input int idx);
    int x, y, s;
    x = idx % out_w(m);
    y = idx / out_w(m);
    case (m)
      0: return int'(ram[y * W + x]);
      1: return int'(ram[(y / 2) * W + x / 2]);
      2: return int'(ram[2 * y * W + 2 * x]);
      default: begin
        s = int'(ram[2*y*W + 2*x]) + int'(ram[2*y*W + 2*x + 1])
          + int'(ram[(2*y+1)*W + 2*x]) + int'(ram[(2*y+1)*W + 2*x + 1]);
`ifdef ZOOM_BA_ROUND_EN
        return (s + 2) >> 2;
`else
        return s >> 2;
`endif
      end
    endcase
  endfunction

  task automatic run_frame(input int img, input int alg, input int rdy_pct,
                           input int mid_at, input int abort_at, input int exp_lat);
    int m, total, idx, cyc, held;
    bit first, stalled, mid_done, ended;
    m = mode_of(img, alg);
    total = out_w(m) * out_h(m);
    idx = 0; first = 1; stalled = 0; mid_done = 0; ended = 0; held = 0;
    @(negedge clk);
    start = 1'b1; algorithm = 2'(alg); image_state = 2'(img);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("busy_after_start", busy, 1);
    for (int c = 0; c < 6000 && !ended; c++) begin
      if (idx == total) begin
        check("done_pulse", done, 1);
        check("busy_in_fin", busy, 0);
        ended = 1;
      end else begin
        if (done) check("early_done", done, 0);
        if (first && dst_valid) begin
          check("latency", cyc, exp_lat);
          first = 0;
        end
        if (stalled) begin
          check("hold_valid", dst_valid, 1);
          check("hold_data", dst_data, held);
        end
        if (abort_at >= 0 && idx == abort_at && dst_valid) begin
          resetn = 1'b0; dst_ready = 1'b0; start = 1'b0;
          @(negedge clk);
          check("reset_outs", {src_rd, src_addr, dst_data, dst_valid, dst_last, busy, done}, 0);
          resetn = 1'b1;
          repeat (6) @(negedge clk);
          check("no_resume", {busy, dst_valid, src_rd}, 0);
          ended = 1;
        end else begin
          if (mid_at >= 0 && idx == mid_at && !mid_done) begin
            start = 1'b1;
            mid_done = 1;
          end else begin
            start = 1'b0;
          end
          dst_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
          if (dst_valid && dst_ready) begin
            check("pix", dst_data, exp_val(m, idx));
            check("last", dst_last, (idx == total - 1));
            out_buf[idx] = int'(dst_data);
            idx++;
            stalled = 0;
          end else if (dst_valid) begin
            stalled = 1;
            held = int'(dst_data);
          end else begin
            stalled = 0;
          end
          @(negedge clk);
          cyc++;
        end
      end
    end
    if (!ended) check("timeout", 0, 1);
    start = 1'b0;
    got_count = idx;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; algorithm = 2'd0; image_state = 2'd0; dst_ready = 1'b0;
    fill_ramp();
    repeat (3) @(negedge clk);
    check("reset_state", {src_rd, src_addr, dst_data, dst_valid, dst_last, busy, done}, 0);
    resetn = 1'b1;
    @(negedge clk);

    run_frame(0, 0, 100, -1, -1, 3);
    check("copy_count", got_count, W * H);
    check("copy_p0", out_buf[0], 0);
    check("copy_p9", out_buf[9], 9);
    check("copy_p47", out_buf[47], 47);

    run_frame(3, 2, 30, 5, -1, 3);
    check("copy3_count_midstart", got_count, W * H);

    run_frame(1, 1, 100, -1, -1, 3);
    check("enl_count", got_count, 4 * W * H);
    check("enl_x3y5", out_buf[5 * 2 * W + 3], 17);
    check("enl_last", out_buf[4 * W * H - 1], 47);

    run_frame(2, 0, 30, -1, -1, 3);
    check("dec_count", got_count, W * H / 4);
    check("dec_x1y0", out_buf[1], 2);
    check("dec_x0y1", out_buf[4], 16);
    check("dec_x3y2", out_buf[11], 38);

    run_frame(2, 3, 100, -1, -1, 9);
    check("avg_ramp_p0", out_buf[0], AVG_RAMP0);

    fill_blocks();
    run_frame(2, 3, 100, -1, -1, 9);
    check("avg_count", got_count, W * H / 4);
    check("avg_blk_p0", out_buf[0], AVG_BLK);
    check("avg_blk_p11", out_buf[11], AVG_BLK);

    fill_ramp();
    run_frame(1, 1, 100, -1, 100, 3);
    check("abort_count", got_count, 100);
    run_frame(1, 1, 100, -1, -1, 3);
    check("fresh_count", got_count, 4 * W * H);
    check("fresh_p0", out_buf[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
